// File: rtl/fifo_mux_2_slot.sv
// stream_slot: one-entry valid/ready buffer. A full slot accepts a new word
// in the same cycle it is popped, which keeps streaming at full rate.
module stream_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] data
);

    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t state, state_nxt;
    logic        push;

    always_comb begin
        state_nxt = state;
        in_ready  = (state == EMPTY) || pop;
        push      = in_valid && in_ready;
        case (state)
            EMPTY: if (push) state_nxt = FULL;
            FULL:  if (pop && !push) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            data  <= '0;
        end else begin
            state <= state_nxt;
            if (push) data <= in_data;
        end
    end

    assign full = (state == FULL);

endmodule

// File: rtl/fifo_mux_2.sv
// fifo_mux_2: routes one word from buffered stream A or B to result per
// buffered select token; tokens complete strictly in order.
module fifo_mux_2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             select,
    input  logic             select_valid,
    output logic             select_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    logic             a_full, b_full, sel_full;
    logic [WIDTH-1:0] a_data, b_data;
    logic [0:0]       sel_data;
    logic             sel_q;
    logic             pop, pop_a, pop_b;

    stream_slot #(.W(WIDTH)) buf_a (
        .clk(clk), .rst(rst), .in_data(a), .in_valid(a_valid), .in_ready(a_ready),
        .pop(pop_a), .full(a_full), .data(a_data)
    );

    stream_slot #(.W(WIDTH)) buf_b (
        .clk(clk), .rst(rst), .in_data(b), .in_valid(b_valid), .in_ready(b_ready),
        .pop(pop_b), .full(b_full), .data(b_data)
    );

    stream_slot #(.W(1)) buf_sel (
        .clk(clk), .rst(rst), .in_data(select), .in_valid(select_valid),
        .in_ready(select_ready), .pop(pop), .full(sel_full), .data(sel_data)
    );

    assign sel_q = sel_data[0];

    // A stalled token blocks the select slot until its data buffer fills.
    always_comb begin
        result_valid = sel_full && (sel_q ? b_full : a_full);
        result       = '0;
        if (result_valid) result = sel_q ? b_data : a_data;
        pop   = result_valid && result_ready;
        pop_a = pop && !sel_q;
        pop_b = pop && sel_q;
    end

endmodule

// File: tb/tb_fifo_mux_2.sv
// Self-checking bench for fifo_mux_2: queue-based model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_mux_2;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             a_valid = 1'b0, b_valid = 1'b0;
    logic             select = 1'b0, select_valid = 1'b0;
    logic             result_ready = 1'b0;
    logic             a_ready, b_ready, select_ready, result_valid;
    logic [WIDTH-1:0] result;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned model_pops = 0;

    // Model: each buffer is a queue of at most one entry.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic             qs[$];

    fifo_mux_2 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .b(b), .b_valid(b_valid), .b_ready(b_ready),
        .select(select), .select_valid(select_valid), .select_ready(select_ready),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_valid();
        if (qs.size() == 0) return 1'b0;
        return qs[0] ? (qb.size() != 0) : (qa.size() != 0);
    endfunction

    function automatic logic [WIDTH-1:0] m_result();
        if (!m_valid()) return '0;
        return qs[0] ? qb[0] : qa[0];
    endfunction

    function automatic logic m_pop_a();
        return m_valid() && result_ready && !qs[0];
    endfunction

    function automatic logic m_pop_b();
        return m_valid() && result_ready && qs[0];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                qa.delete(); qb.delete(); qs.delete();
            end else begin
                logic pa, pb, ps, ra, rb, rs;
                pa = m_pop_a();
                pb = m_pop_b();
                ps = pa || pb;
                ra = (qa.size() == 0) || pa;
                rb = (qb.size() == 0) || pb;
                rs = (qs.size() == 0) || ps;
                if (ps) begin
                    void'(qs.pop_front());
                    model_pops++;
                end
                if (pa) void'(qa.pop_front());
                if (pb) void'(qb.pop_front());
                if (a_valid && ra) qa.push_back(a);
                if (b_valid && rb) qb.push_back(b);
                if (select_valid && rs) qs.push_back(select);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_result_valid", {31'd0, result_valid}, {31'd0, m_valid()});
        chk("model_result", result, m_result());
        chk("model_a_ready", {31'd0, a_ready}, {31'd0, (qa.size() == 0) || m_pop_a()});
        chk("model_b_ready", {31'd0, b_ready}, {31'd0, (qb.size() == 0) || m_pop_b()});
        chk("model_select_ready", {31'd0, select_ready},
            {31'd0, (qs.size() == 0) || m_pop_a() || m_pop_b()});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rv"}, {31'd0, result_valid}, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_a_ready"}, {31'd0, a_ready}, 32'd1);
        chk({tag, "_b_ready"}, {31'd0, b_ready}, 32'd1);
        chk({tag, "_sel_ready"}, {31'd0, select_ready}, 32'd1);
    endtask

    task automatic pop_one();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    int unsigned pops_before;

    initial begin
        #3;
        chk_idle("reset_hold");
        step(); step();
        chk_idle("reset_hold2");
        rst = 1'b1;
        step();
        chk_idle("after_release");

        // Route A with separated pulses
        a = 32'd100; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("a_only_rv", {31'd0, result_valid}, 32'd0);
        chk("a_only_a_ready", {31'd0, a_ready}, 32'd0);
        select = 1'b0; select_valid = 1'b1;
        step();
        select_valid = 1'b0;
        chk("route_a_rv", {31'd0, result_valid}, 32'd1);
        chk("route_a_result", result, 32'd100);
        step(); step();
        chk("route_a_stable_rv", {31'd0, result_valid}, 32'd1);
        chk("route_a_stable_result", result, 32'd100);
        chk("route_a_stable_a_ready", {31'd0, a_ready}, 32'd0);
        pop_one();
        chk_idle("route_a_popped");

        // B then A ordering
        a = 32'd100; a_valid = 1'b1; b = 32'd256; b_valid = 1'b1;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        select = 1'b1; select_valid = 1'b1;
        step();
        select_valid = 1'b0;
        chk("ba_first_result", result, 32'd256);
        chk("ba_a_held", {31'd0, a_ready}, 32'd0);
        pop_one();
        chk("ba_a_still_held", {31'd0, a_ready}, 32'd0);
        select = 1'b0; select_valid = 1'b1;
        step();
        select_valid = 1'b0;
        chk("ba_second_result", result, 32'd100);
        pop_one();
        chk_idle("ba_drained");

        // Token before data
        select = 1'b1; select_valid = 1'b1;
        step();
        select_valid = 1'b0;
        chk("tok_first_rv", {31'd0, result_valid}, 32'd0);
        chk("tok_first_sel_ready", {31'd0, select_ready}, 32'd0);
        step();
        chk("tok_wait_rv", {31'd0, result_valid}, 32'd0);
        b = 32'd256; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        chk("tok_then_b_rv", {31'd0, result_valid}, 32'd1);
        chk("tok_then_b_result", result, 32'd256);
        pop_one();
        chk_idle("tok_drained");

        // Continuous streaming, tokens alternating 0/1
        pops_before = model_pops;
        a = 32'd100; b = 32'd256;
        a_valid = 1'b1; b_valid = 1'b1; select_valid = 1'b1; result_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            select = 1'(i % 2);
            step();
            chk("stream_rv", {31'd0, result_valid}, 32'd1);
            chk("stream_result", result, (i % 2 != 0) ? 32'd256 : 32'd100);
        end
        chk("stream_pop_count", model_pops - pops_before, 32'd15);
        a_valid = 1'b0; b_valid = 1'b0; select_valid = 1'b0;
        step();
        result_ready = 1'b0;
        chk("stream_drain_rv", {31'd0, result_valid}, 32'd0);
        chk("stream_drain_a_ready", {31'd0, a_ready}, 32'd0);

        // Reset mid-operation: A still holds a word from streaming
        select = 1'b0; select_valid = 1'b1;
        step();
        select_valid = 1'b0;
        chk("pre_reset_rv", {31'd0, result_valid}, 32'd1);
        chk("pre_reset_result", result, 32'd100);
        #1;
        rst = 1'b0;
        #1;
        chk_idle("async_reset");
        step();
        rst = 1'b1;
        step();
        chk_idle("post_reset");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_mux_2.md
# fifo_mux_2

Two-input stream multiplexer with a third stream supplying the select token. Each of `a`, `b` and `select` enters through its own one-entry buffer. Each accepted select token routes exactly one word from the chosen input buffer to `result` under valid/ready flow control. It sits between producer stages in the backpropagation datapath, for example to choose between two operand sources per transaction.

## Interface
- `WIDTH`, default 32: data width of `a`, `b` and `result`.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted at 0).
- `a`  in  WIDTH: input stream A data.
- `a_valid`  in  1: A data valid.
- `a_ready`  out  1: A buffer can accept a word.
- `b`  in  WIDTH: input stream B data.
- `b_valid`  in  1: B data valid.
- `b_ready`  out  1: B buffer can accept a word.
- `select`  in  1: routing token; 0 selects A, 1 selects B.
- `select_valid`  in  1: token valid.
- `select_ready`  out  1: token buffer can accept a token.
- `result`  out  WIDTH: selected word.
- `result_valid`  out  1: `result` holds a routed word.
- `result_ready`  in  1: downstream accepts `result`.

## Operation
- Three one-entry buffers, `buf_a`, `buf_b` and `buf_sel`. Each holds a data register and a `full` flag. States are EMPTY and FULL.
- A transfer occurs on a port when valid && ready at a rising edge. On a transfer, the buffer latches the data and goes FULL.
- `sel_q` is the token held in `buf_sel`.
- `result_valid` = `buf_sel.full && (sel_q ? buf_b.full : buf_a.full)`.
- `result` = `sel_q ? buf_b.data : buf_a.data` when `result_valid` = 1, otherwise 0.
- A pop happens when `result_valid && result_ready`. It empties `buf_sel` and the selected data buffer.
- The unselected buffer keeps its word until a later token selects it. Words are never dropped or duplicated.
- `x_ready` = `!x.full || pop_x`. This gives a full-rate pass-through: a buffer may be popped and refilled in the same cycle.
- A token whose data buffer is empty stalls in place. Further tokens are refused until it completes. Tokens complete strictly in order.
- Input data arriving before its token waits indefinitely.

## Timing
- Reset (rst=0) asynchronously clears all `full` flags and data registers.
- During reset: `a_ready`, `b_ready` and `select_ready` = 1; `result_valid` = 0; `result` = 0.
- Reset mid-transaction discards all buffered words and tokens.
- Latency: data and token both accepted at edge N gives `result_valid` = 1 after edge N, combinationally from the registers. Minimum latency is one cycle.
- Data and token may arrive in any order, in any cycles.
- `result` and `result_valid` are stable while `result_ready` = 0.
- Throughput: one result per cycle when all streams are continuously valid and `result_ready` = 1.
- The `x_ready` to `result_ready` path is combinational. Downstream must not make `result_ready` depend on `x_ready`.
- Single-cycle valid pulses (one clock period) are captured when ready = 1.

## Structure
- No shared package is needed. `WIDTH` is the only constant.
- Natural sub-module: `stream_slot`, a parameterised one-entry valid/ready buffer with `push`/`pop`/`full`/`data`. Instantiate it three times: `WIDTH` for A and B, 1 for select.
- The top level holds only the routing mux and the pop decode.

## Test plan
- Reset: hold rst=0 -> `result_valid`=0, `result`=0, all readies=1. Release -> unchanged until any push.
- Route A with separated pulses, `a`=100:
  - `a_valid` pulsed 1 cycle, then `select`=0/`select_valid` pulsed 1 cycle, then `result_ready` held 0 -> `result_valid`=1, `result`=100, stable, `a_ready`=0.
  - `result_ready` pulsed 1 cycle -> `result_valid`=0 next cycle, all readies=1.
- B then A ordering, `a`=100, `b`=256:
  - Push A and B, then token 1 -> `result`=256. Pop.
  - Token 0 -> `result`=100. Pop -> all buffers empty.
- Token before data: token 1 with B empty -> `result_valid`=0 and `select_ready`=0. Later `b_valid` with `b`=256 -> `result`=256 one cycle after acceptance.
- Continuous streaming: all valids=1, `result_ready`=1, token alternating 0/1 -> one result per cycle, values alternating 100/256, no drops.
- Reset mid-operation: buffers full and `result_valid`=1, assert rst -> `result_valid`=0 immediately, asynchronously. All readies=1 after release.
